uart_tx_fifo: RTL and testbench

Byte buffer and issue sequencer that sits directly upstream of the `uart` top-level. It accepts bytes from the bus side over a valid/ready handshake and stores them in a DEPTH-entry FIFO. It drives the UART's `wr_en`/`data_in` pair one byte at a time, pacing issue from `Tx_busy` so that no byte is written while the transmitter is busy. It lets bus masters burst up to DEPTH bytes without stalling on the serial line rate.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_fifo_if.sv | 11 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_tx_fifo.sv | 97 +++++++++
 tb/tb_uart_tx_fifo.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: issue FSM encoding and
// width helpers for the byte FIFO.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_t;

    // Pointer width for a power-of-two FIFO; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy needs one extra bit so that DEPTH itself is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bus-side valid/ready byte handshake into the UART transmit FIFO.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; occupancy count alone separates full from empty so the
// pointers can wrap freely modulo DEPTH.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   push,
    input  logic [DATA_BITS-1:0]   wr_data,
    input  logic                   pop,
    output logic [DATA_BITS-1:0]   rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage is deliberately not reset; count gates every read, so stale
    // entries are never observed and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (!clear && do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer ahead of the UART transmitter: queues bus bytes and issues them
// one at a time as wr_en/data_in strobes, paced by Tx_busy.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                   clk_50m,
    input  logic                   clear,
    uart_tx_fifo_if.slave          bus,
    output logic [DATA_BITS-1:0]   data_in,
    output logic                   wr_en,
    input  logic                   Tx_busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   tx_err
);
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

    tx_state_t            state;
    logic [TO_W-1:0]      to_cnt;
    logic [DATA_BITS-1:0] head;
    logic                 push;
    logic                 pop;

    assign bus.s_ready = !full && !clear;
    assign push        = bus.s_valid && bus.s_ready;
    // The UART has no reset, so a byte in flight may still hold Tx_busy after
    // clear; gating the pop on !Tx_busy covers that case as well.
    assign pop         = (state == ST_IDLE) && !empty && !Tx_busy && !clear;

    sync_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk     (clk_50m),
        .clear   (clear),
        .push    (push),
        .wr_data (bus.s_data),
        .pop     (pop),
        .rd_data (head),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    // wr_en is the registered output of ISSUE: it is high for the single cycle
    // that follows the ISSUE state, while data_in holds the popped byte.
    always_ff @(posedge clk_50m) begin
        if (clear) begin
            state   <= ST_IDLE;
            data_in <= '0;
            wr_en   <= 1'b0;
            tx_err  <= 1'b0;
            to_cnt  <= '0;
        end else begin
            // NOTE: pulse outputs default low each cycle; with non-blocking
            // assignments the later branch assignment simply overrides this.
            wr_en  <= 1'b0;
            tx_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pop) begin
                        data_in <= head;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wr_en  <= 1'b1;
                    to_cnt <= '0;
                    state  <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (Tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                        // Byte is treated as consumed; no retry.
                        tx_err <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!Tx_busy) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a byte scoreboard and a simple
// transmitter model that raises Tx_busy after each strobe.
module tb_uart_tx_fifo;
    localparam int DATA_BITS   = 8;
    localparam int DEPTH       = 16;
    localparam int ACK_TIMEOUT = 4;

    logic                 clk_50m = 1'b0;
    logic                 clear;
    logic [DATA_BITS-1:0] data_in;
    logic                 wr_en;
    logic                 tx_busy;
    logic [4:0]           count;
    logic                 empty;
    logic                 full;
    logic                 tx_err;

    uart_tx_fifo_if #(.DATA_BITS(DATA_BITS)) bus ();

    uart_tx_fifo #(
        .DATA_BITS   (DATA_BITS),
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk_50m (clk_50m),
        .clear   (clear),
        .bus     (bus),
        .data_in (data_in),
        .wr_en   (wr_en),
        .Tx_busy (tx_busy),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .tx_err  (tx_err)
    );

    always #5 clk_50m = ~clk_50m;

    int             checks     = 0;
    int             errors     = 0;
    int             strobes    = 0;
    int             err_pulses = 0;
    logic           prev_wr    = 1'b0;
    logic [7:0]     sb[$];

    // Transmitter model: busy for busy_len cycles starting the edge after wr_en.
    int   busy_len   = 4;
    int   model_cnt  = 0;
    logic model_en   = 1'b1;
    logic force_busy = 1'b0;

    assign tx_busy = force_busy || (model_cnt != 0);

    always @(posedge clk_50m) begin
        if (model_en && wr_en === 1'b1) model_cnt <= busy_len;
        else if (model_cnt != 0)        model_cnt <= model_cnt - 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: every wr_en must be single-cycle and carry the next queued byte.
    always @(negedge clk_50m) begin
        if (wr_en === 1'b1) begin
            strobes++;
            check("wr_en_single_cycle", 32'(prev_wr), 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_strobe: data_in 0x%0h with no byte queued", data_in);
            end else begin
                check("strobe_data", 32'(data_in), 32'(sb.pop_front()));
            end
        end
        if (tx_err === 1'b1) err_pulses++;
        prev_wr = wr_en;
    end

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_50m);
    endtask

    task automatic push_burst(input logic [7:0] first, input int n, input int budget);
        int waited;
        for (int i = 0; i < n; i++) begin
            waited      = 0;
            bus.s_data  = first + 8'(i);
            bus.s_valid = 1'b1;
            while (bus.s_ready !== 1'b1 && waited < budget) begin
                tick();
                waited++;
            end
            if (bus.s_ready !== 1'b1) begin
                check("push_ready_timeout", 32'(bus.s_ready), 32'd1);
                break;
            end
            sb.push_back(first + 8'(i));
            tick();
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((sb.size() != 0 || tx_busy) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(sb.size()), 32'd0);
        repeat (busy_len + 12) tick();
    endtask

    initial begin
        int base;
        int base_err;
        int n;
        logic saw_low;
        logic seen;

        // Reset with s_valid asserted: nothing may be accepted.
        clear       = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h55;
        repeat (3) tick();
        sample();
        check("rst_s_ready", 32'(bus.s_ready), 32'd0);
        check("rst_count",   32'(count),       32'd0);
        check("rst_empty",   32'(empty),       32'd1);
        check("rst_wr_en",   32'(wr_en),       32'd0);
        check("rst_data_in", 32'(data_in),     32'd0);
        check("rst_tx_err",  32'(tx_err),      32'd0);
        tick();
        clear       = 1'b0;
        bus.s_valid = 1'b0;
        sample();
        check("post_rst_ready", 32'(bus.s_ready), 32'd1);
        check("post_rst_count", 32'(count),       32'd0);

        // Single byte: strobe 2 cycles after the push, then a long busy period.
        busy_len = 100;
        base     = strobes;
        push_burst(8'hA5, 1, 50);
        sample();
        check("single_count_n",  32'(count), 32'd1);
        check("single_wr_n",     32'(wr_en), 32'd0);
        tick(); sample();
        check("single_wr_n1",    32'(wr_en), 32'd0);
        check("single_count_n1", 32'(count), 32'd0);
        tick(); sample();
        check("single_wr_n2",    32'(wr_en),   32'd1);
        check("single_data_n2",  32'(data_in), 32'hA5);
        tick(); sample();
        check("single_wr_n3",    32'(wr_en),   32'd0);
        check("single_busy_n3",  32'(tx_busy), 32'd1);
        repeat (100) tick();
        check("single_strobes",  32'(strobes - base), 32'd1);
        check("single_data_hold", 32'(data_in), 32'hA5);

        // Fill to DEPTH with the transmitter held busy.
        busy_len   = 5;
        force_busy = 1'b1;
        base       = strobes;
        push_burst(8'h00, DEPTH, 50);
        sample();
        check("full_flag",    32'(full),          32'd1);
        check("full_count",   32'(count),         32'd16);
        check("full_s_ready", 32'(bus.s_ready),   32'd0);
        bus.s_data  = 8'hEE;
        bus.s_valid = 1'b1;
        tick(); tick();
        bus.s_valid = 1'b0;
        sample();
        check("full_ignore_count", 32'(count),          32'd16);
        check("full_no_strobe",    32'(strobes - base), 32'd0);
        force_busy = 1'b0;
        wait_drain("drain16", 400);
        check("strobes16",   32'(strobes - base), 32'd16);
        check("drain_empty", 32'(empty),          32'd1);

        // 20 bytes through a 16-entry FIFO: exercises backpressure and wrap.
        base = strobes;
        push_burst(8'h30, 20, 200);
        wait_drain("drain20", 600);
        check("strobes20", 32'(strobes - base), 32'd20);

        // Push in the same cycle as an IDLE pop keeps count at 3.
        force_busy = 1'b1;
        base       = strobes;
        push_burst(8'h61, 3, 50);
        sample();
        check("simul_pre_count", 32'(count), 32'd3);
        force_busy  = 1'b0;
        bus.s_data  = 8'h64;
        bus.s_valid = 1'b1;
        sb.push_back(8'h64);
        tick();
        bus.s_valid = 1'b0;
        sample();
        check("simul_count", 32'(count), 32'd3);
        wait_drain("drain_simul", 200);
        check("simul_strobes", 32'(strobes - base), 32'd4);

        // Timeout: Tx_busy never rises, each byte errors once and is not retried.
        model_en = 1'b0;
        base     = strobes;
        base_err = err_pulses;
        push_burst(8'h71, 2, 50);
        n = 0;
        sample();
        while (wr_en !== 1'b1 && n < 20) begin
            sample();
            n++;
        end
        check("to_first_strobe", 32'(wr_en), 32'd1);
        for (int k = 1; k <= ACK_TIMEOUT + 1; k++) begin
            sample();
            check($sformatf("to_tx_err_%0d", k), 32'(tx_err), 32'(k == ACK_TIMEOUT));
        end
        wait_drain("drain_timeout", 100);
        check("to_strobes",   32'(strobes - base),     32'd2);
        check("to_err_count", 32'(err_pulses - base_err), 32'd2);

        // Clear while WAIT_DONE with 5 bytes queued; transmitter keeps running.
        model_en = 1'b1;
        busy_len = 30;
        base     = strobes;
        push_burst(8'h81, 6, 50);
        repeat (5) tick();
        sample();
        check("mid_count", 32'(count),   32'd5);
        check("mid_busy",  32'(tx_busy), 32'd1);
        clear = 1'b1;
        sb.delete();
        tick();
        clear = 1'b0;
        sample();
        check("mid_clr_count", 32'(count), 32'd0);
        check("mid_clr_empty", 32'(empty), 32'd1);
        check("mid_clr_wr_en", 32'(wr_en), 32'd0);
        push_burst(8'h99, 1, 50);
        saw_low = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            sample();
            if (tx_busy === 1'b0) saw_low = 1'b1;
            if (wr_en === 1'b1) begin
                seen = 1'b1;
                check("mid_issue_after_busy_low", 32'(saw_low), 32'd1);
                break;
            end
        end
        check("mid_new_strobe", 32'(seen), 32'd1);
        wait_drain("drain_mid", 200);
        check("mid_strobes", 32'(strobes - base), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
